// File: rtl/decoder_pkg.sv
// Shared decode helpers for the one-hot decoder family.
package decoder_pkg;

  localparam int unsigned MaxInW  = 8;
  localparam int unsigned MaxOutW = 1 << MaxInW;

  function automatic int unsigned out_width(input int unsigned in_w);
    return 1 << in_w;
  endfunction

  // Full-width result; callers size-cast down to their OUT_W.
  function automatic logic [MaxOutW-1:0] onehot_decode(input logic [MaxInW-1:0] code,
                                                       input logic              en);
    logic [MaxOutW-1:0] word;
    word = '0;
    if (en) word[code] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready skid buffer; main entry drives the outputs directly.
module skid_buf_2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer, out_xfer;

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (out_xfer) begin
      if (skid_valid_q) begin
        // in_ready was low, so no input competes for main here.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        main_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/decoder_24_pipe.sv
// Registered binary-to-one-hot decoder with skid-buffered handshakes and a saturating
// delivered-word counter.
module decoder_24_pipe
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned OUT_W = out_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_y,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] dec_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [OUT_W-1:0] word;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign word = OUT_W'(onehot_decode(MaxInW'(in_code), in_en));

  skid_buf_2 #(
    .WIDTH(OUT_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_y)
  );

  // Clear takes priority over a coincident transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dec_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_24_pipe.sv
// Directed and randomized-handshake checks of decoder_24_pipe (default, CNT_W=4, IN_W=3).
module tb_decoder_24_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0, in_en = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [1:0] in_code = '0;
  logic       in_ready, out_valid;
  logic [3:0] out_y;
  logic [7:0] dec_cnt;

  logic       in_valid4 = 1'b0, out_ready4 = 1'b0, cnt_clr4 = 1'b0;
  logic       in_ready4, out_valid4;
  logic [3:0] out_y4;
  logic [3:0] dec_cnt4;

  logic       in_valid3 = 1'b0, in_en3 = 1'b0, out_ready3 = 1'b0;
  logic [2:0] in_code3 = '0;
  logic       in_ready3, out_valid3;
  logic [7:0] out_y3;
  logic [7:0] dec_cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decoder_24_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cnt_clr(cnt_clr), .dec_cnt(dec_cnt)
  );

  decoder_24_pipe #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_code(2'd1),
    .in_en(1'b1), .out_valid(out_valid4), .out_ready(out_ready4), .out_y(out_y4),
    .cnt_clr(cnt_clr4), .dec_cnt(dec_cnt4)
  );

  decoder_24_pipe #(.IN_W(3)) dut_w3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_code(in_code3),
    .in_en(in_en3), .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3),
    .cnt_clr(1'b0), .dec_cnt(dec_cnt3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ref_q[$];
  logic [3:0] exp_w, prev_y;
  logic       prev_stall;
  int         exp_cnt;
  int         guard;

  initial begin
    step();
    step();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_dec_cnt", dec_cnt, 0);
    rst = 1'b0;

    // 1: back-to-back codes 0..3
    in_valid = 1'b1; in_en = 1'b1; out_ready = 1'b1; in_code = 2'd0;
    step(); check_eq("t1_valid0", out_valid, 1); check_eq("t1_y0", out_y, 4'b0001);
    in_code = 2'd1;
    step(); check_eq("t1_y1", out_y, 4'b0010); check_eq("t1_rdy1", in_ready, 1);
    in_code = 2'd2;
    step(); check_eq("t1_y2", out_y, 4'b0100);
    in_code = 2'd3;
    step(); check_eq("t1_y3", out_y, 4'b1000); check_eq("t1_rdy3", in_ready, 1);
    in_valid = 1'b0;
    step(); check_eq("t1_cnt", dec_cnt, 4); check_eq("t1_idle", out_valid, 0);

    // 2: disabled decode gives an all-zero word that still counts
    in_valid = 1'b1; in_en = 1'b0; in_code = 2'd2;
    step(); check_eq("t2_valid", out_valid, 1); check_eq("t2_y", out_y, 4'b0000);
    in_valid = 1'b0;
    step(); check_eq("t2_cnt", dec_cnt, 5);

    // 3: backpressure fills skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1; in_en = 1'b1; in_code = 2'd1;
    step(); check_eq("t3_rdy_a", in_ready, 1); check_eq("t3_y_a", out_y, 4'b0010);
    in_code = 2'd3;
    step(); check_eq("t3_rdy_b", in_ready, 0);
    in_code = 2'd0;
    step(); check_eq("t3_hold_rdy", in_ready, 0); check_eq("t3_hold_y", out_y, 4'b0010);
    out_ready = 1'b1;
    step(); check_eq("t3_y_b", out_y, 4'b1000); check_eq("t3_rdy_back", in_ready, 1);
    check_eq("t3_cnt_b", dec_cnt, 6);
    step(); check_eq("t3_y_c", out_y, 4'b0001); check_eq("t3_cnt_c", dec_cnt, 7);
    in_valid = 1'b0;
    step(); check_eq("t3_idle", out_valid, 0); check_eq("t3_cnt", dec_cnt, 8);

    // 4: random handshakes against a reference queue
    exp_cnt = 8;
    prev_stall = 1'b0;
    prev_y = '0;
    for (int i = 0; i < 1000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_en     = ($urandom_range(0, 7) != 0);
      in_code   = 2'($urandom_range(0, 3));
      if (prev_stall) check_eq("t4_stable", out_y, prev_y);
      if (out_valid && out_ready) begin
        if (ref_q.size() == 0) check_eq("t4_spurious", 1, 0);
        else check_eq("t4_data", out_y, ref_q.pop_front());
        if (exp_cnt < 255) exp_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_w = in_en ? (4'b0001 << in_code) : 4'b0000;
        ref_q.push_back(exp_w);
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    guard = 0;
    while (out_valid && guard < 10) begin
      if (ref_q.size() == 0) check_eq("t4_extra", 1, 0);
      else check_eq("t4_drain", out_y, ref_q.pop_front());
      if (exp_cnt < 255) exp_cnt++;
      guard++;
      step();
    end
    check_eq("t4_drain_bound", guard < 10, 1);
    check_eq("t4_lost", ref_q.size(), 0);
    check_eq("t4_cnt", dec_cnt, exp_cnt);
    cnt_clr = 1'b1;
    step(); check_eq("t4_clr", dec_cnt, 0);
    cnt_clr = 1'b0;

    // 5: 4-bit counter saturates, clear beats a simultaneous transfer
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    for (int i = 0; i < 20; i++) step();
    in_valid4 = 1'b0;
    step(); check_eq("t5_sat", dec_cnt4, 15);
    in_valid4 = 1'b1;
    step(); check_eq("t5_valid", out_valid4, 1); check_eq("t5_y", out_y4, 4'b0010);
    in_valid4 = 1'b0; cnt_clr4 = 1'b1;
    step(); check_eq("t5_clr_win", dec_cnt4, 0);
    cnt_clr4 = 1'b0;

    // 6: async reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; in_en = 1'b1; in_code = 2'd2;
    step();
    step(); check_eq("t6_full", in_ready, 0);
    check_eq("t6_cnt_pre", dec_cnt, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_rdy", in_ready, 1);
    check_eq("t6_rst_y", out_y, 0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;

    // IN_W=3 instance
    in_valid3 = 1'b1; in_en3 = 1'b1; out_ready3 = 1'b1; in_code3 = 3'd5;
    step(); check_eq("t6_w3_c5", out_y3, 8'b0010_0000);
    in_code3 = 3'd7;
    step(); check_eq("t6_w3_c7", out_y3, 8'b1000_0000);
    in_en3 = 1'b0;
    step(); check_eq("t6_w3_dis", out_y3, 8'b0000_0000);
    in_valid3 = 1'b0;
    step(); check_eq("t6_w3_cnt", dec_cnt3, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_24_pipe.md
Name: decoder_24_pipe

Overview:
Registered binary-to-one-hot decoder: IN_W-bit code in, 2**IN_W-bit one-hot word out. It is the inverse of the team's 4:2 priority-free encoder.
- Sits between a code-producing stage and a one-hot consumer, e.g. select lines, LED/row drivers or mux controls.
- Both sides use valid/ready handshakes, with a 2-entry skid buffer for full throughput under backpressure.
- A saturating counter of delivered words supports debug.

Parameters:
IN_W, 2, width of input code
OUT_W, 2**IN_W (derived localparam, not overridable), width of one-hot output
CNT_W, 8, width of delivered-word counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept input word this cycle
in_code  input  IN_W  binary code to decode
in_en  input  1  decoder enable, captured with the code; 0 yields all-zero output word
out_valid  output  1  output word present
out_ready  input  1  consumer accepts output word this cycle
out_y  output  OUT_W  decoded one-hot (or all-zero) word
cnt_clr  input  1  synchronous clear of dec_cnt
dec_cnt  output  CNT_W  number of completed output handshakes, saturating

Behaviour:
- Reset (async assert, registers cleared immediately; release synchronous to clk):
  - main_valid=0, skid_valid=0, out_valid=0
  - out_y=0, dec_cnt=0
  - in_ready=1
- Transfer rules:
  - Input transfer when in_valid & in_ready at the rising edge.
  - Output transfer when out_valid & out_ready.
- Decode function, applied at capture:
  - word = in_en ? (1 << in_code) : 0
  - Exactly one bit set when in_en=1; no out-of-range code exists, since all IN_W codes map.
- Storage:
  - main register drives out_y/out_valid directly (registered outputs).
  - skid register holds one overflow word.
- in_ready = !skid_valid (flop-derived, no combinational path from out_ready).
- Per clock edge, evaluated with pre-edge values:
  - main empty, or main transferring out, and skid empty: an accepted input loads main.
  - main full and not transferring, and input accepted: the word loads skid.
  - main transferring and skid full: main <= skid, skid_valid <= 0. in_ready was 0, so no input is accepted that cycle.
  - main transferring with no replacement: main_valid <= 0. out_y holds its last value, which is don't-care when out_valid=0.
- Latency: 1 cycle from input transfer to out_valid, when main is empty or draining.
- Throughput: 1 word/cycle with out_ready held high.
- Ordering: strict FIFO; no word is dropped or duplicated.
- in_valid/in_code/in_en may change freely while in_ready=0. The block ignores them.
- out_valid, once high, stays high with out_y stable until transferred. The block never retracts a word.
- dec_cnt:
  - +1 on each output transfer, saturating at 2**CNT_W-1.
  - cnt_clr=1 forces 0 next edge; clr wins over a simultaneous transfer.
- Reset mid-operation: buffered words are discarded, the count is lost, and outputs go to reset values within the same cycle.

Decomposition:
- Shared package decoder_pkg:
  - Function onehot_decode(code, en) returning the OUT_W-bit word.
  - Localparam OUT_W derivation helper.
  - No typedefs needed beyond the word width.
- One natural sub-module: skid_buf_2. It is a generic WIDTH-parameterised 2-entry valid/ready skid buffer, reusable by the encoder side later.
- decoder_24_pipe = decode function on the input + skid_buf_2 + counter.

Test Plan:
1. in_en=1, codes 0,1,2,3 back-to-back, out_ready=1. Expected: out_y 0001,0010,0100,1000 on consecutive cycles, each 1 cycle after its input; in_ready stays 1; dec_cnt=4.
2. in_en=0 with code 2. Expected: out_y=0000, out_valid=1; dec_cnt increments.
3. out_ready=0; push codes 1 then 3. Expected: in_ready drops to 0 after the second accept, and code 0 is held off. Release out_ready: delivers 0010, 1000, then 0001 in order; in_ready returns to 1 the cycle after the first drain.
4. Randomly toggle in_valid/out_ready for 1000 cycles against a reference queue. Expected: no loss, duplication or reorder; out_y stable while out_valid & !out_ready.
5. CNT_W=4, 20 transfers. Expected: dec_cnt saturates at 15. Assert cnt_clr in the same cycle as a transfer: dec_cnt=0 next cycle.
6. Assert rst mid-stream with both entries full. Expected: out_valid=0, dec_cnt=0, in_ready=1 immediately. Then IN_W=3 instance, code 5: out_y=00100000.
